// File: rtl/coklu_mux_reg.sv
// coklu_mux_reg: N-input, W-bit registered multiplexer with valid/ready handshakes.
// One of N input channels is granted, either by explicit index or by round-robin.
// The granted word is forwarded through a one-entry output register.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_mode       0 = explicit select via i_sel, 1 = round-robin
//   i_sel        channel index used when i_mode = 0
//   i_in_data    packed channel data, channel i at [i*W +: W]
//   i_in_valid   per-channel valid
//   o_in_ready   per-channel ready, at most one bit high
//   o_out_data   registered selected data
//   o_out_ch     index of the channel held in o_out_data
//   o_out_valid  o_out_data / o_out_ch valid
//   i_out_ready  downstream accepts when high together with o_out_valid
module coklu_mux_reg #(
  parameter int unsigned W  = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_mode,
  input  logic [SW-1:0]  i_sel,
  input  logic [N*W-1:0] i_in_data,
  input  logic [N-1:0]   i_in_valid,
  output logic [N-1:0]   o_in_ready,
  output logic [W-1:0]   o_out_data,
  output logic [SW-1:0]  o_out_ch,
  output logic           o_out_valid,
  input  logic           i_out_ready
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          r_active;
  logic [SW-1:0] r_rr_ptr;
  logic [SW-1:0] r_out_ch;
  logic [W-1:0]  r_out_data;

  logic          w_load;
  logic          w_rdy_en;
  logic          w_sel_ok;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_idx;
  logic          w_offer;
  logic          w_gnt;
  logic [SW-1:0] w_gnt_idx;

  // Output register can take a new word when empty or being drained this cycle.
  assign w_load   = (r_state == StEmpty) || i_out_ready;
  // r_active is low through reset and the first edge after release, so no
  // transfer can complete on the release edge.
  assign w_rdy_en = r_active && w_load;
  assign w_sel_ok = (int'(i_sel) < int'(N));

  // Round-robin search starting at r_rr_ptr. Scanning offsets from high to low
  // lets the smallest offset win.
  always_comb begin
    int v_sum;
    v_sum      = 0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      v_sum = int'(r_rr_ptr) + k;
      if (v_sum >= int'(N)) v_sum = v_sum - int'(N);
      if (i_in_valid[SW'(v_sum)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = SW'(v_sum);
      end
    end
  end

  // In explicit mode ready is offered on sel without looking at its valid,
  // so there is no combinational path from in_valid to in_ready of that channel.
  always_comb begin
    o_in_ready = '0;
    w_gnt_idx  = i_mode ? w_rr_idx : i_sel;
    w_offer    = i_mode ? (w_rdy_en && w_rr_found) : (w_rdy_en && w_sel_ok);
    if (w_offer) o_in_ready[w_gnt_idx] = 1'b1;
    w_gnt = w_offer && i_in_valid[w_gnt_idx];
  end

  always_comb begin
    w_state_next = r_state;
    if (w_load) w_state_next = w_gnt ? StFull : StEmpty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_rr_ptr   <= '0;
      r_out_ch   <= '0;
      r_out_data <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_gnt) begin
        r_out_data <= i_in_data[w_gnt_idx*W +: W];
        r_out_ch   <= w_gnt_idx;
        if (i_mode) begin
          r_rr_ptr <= (int'(w_gnt_idx) == int'(N) - 1) ? '0 : w_gnt_idx + 1'b1;
        end
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_valid = (r_state == StFull);

endmodule
